usr_shift_reg: RTL and testbench

- Parametrised universal shift register built from per-bit flip-flop slices.
- Replaces the single-bit D flip-flop as the storage element for datapath registers, serial/parallel converters and the shifter stage.
- Supports hold, shift left/right, arithmetic shift right, parallel load, clear and (optionally) rotate.
- Tracks shifts since the last load/clear and flags when a full word has been shifted.

---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_bit_slice.sv | 40 ++++
 rtl/usr_shift_reg.sv | 133 +++++++++++++
 tb/tb_usr_shift_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and the
// per-bit next-value select used between the top level and its bit slices.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

  // SEL_LO takes the value arriving from the lower-index side (shift left),
  // SEL_HI the value arriving from the higher-index side (shift right).
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_LO   = 3'd1,
    SEL_HI   = 3'd2,
    SEL_LOAD = 3'd3,
    SEL_ZERO = 3'd4
  } sel_e;

endpackage

// File: rtl/usr_bit_slice.sv
// One storage bit of the universal shift register: next-value mux feeding a
// flip-flop with synchronous active-low reset.
module usr_bit_slice
  import usr_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  sel_e sel_i,
  input  logic lo_i,
  input  logic hi_i,
  input  logic ld_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      SEL_HOLD: q_d = q_q;
      SEL_LO:   q_d = lo_i;
      SEL_HI:   q_d = hi_i;
      SEL_LOAD: q_d = ld_i;
      SEL_ZERO: q_d = 1'b0;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register with shift counter and full-word Done pulse.
// Optional rotate modes (ROL/ROR) are built only when USR_ROTATE_EN is defined.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              SinL,
  input  logic              SinR,
  output logic [WIDTH-1:0]  Q,
  output logic              SoutL,
  output logic              SoutR,
  output logic [CNT_W-1:0]  ShiftCnt,
  output logic              Full,
  output logic              Done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] lo_in;
  logic [WIDTH-1:0] hi_in;
  logic             lo_fill;
  logic             hi_fill;
  sel_e             sel;
  logic             shift_op;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;

  // Decode the operation into one select shared by every slice plus the
  // values entering the two ends of the word.
  always_comb begin
    sel      = SEL_HOLD;
    shift_op = 1'b0;
    cnt_clr  = 1'b0;
    lo_fill  = SinL;
    hi_fill  = SinR;
    if (En) begin
      case (Mode)
        MODE_SHL: begin
          sel      = SEL_LO;
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          sel      = SEL_HI;
          shift_op = 1'b1;
        end
        MODE_ASR: begin
          sel      = SEL_HI;
          hi_fill  = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          sel     = SEL_LOAD;
          cnt_clr = 1'b1;
        end
        MODE_CLR: begin
          sel     = SEL_ZERO;
          cnt_clr = 1'b1;
        end
`ifdef USR_ROTATE_EN
        MODE_ROL: begin
          sel      = SEL_LO;
          lo_fill  = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          sel      = SEL_HI;
          hi_fill  = q_q[0];
          shift_op = 1'b1;
        end
`endif
        default: begin
          sel = SEL_HOLD;
        end
      endcase
    end
  end

  assign lo_in = {q_q[WIDTH-2:0], lo_fill};
  assign hi_in = {hi_fill, q_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    usr_bit_slice u_slice (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .sel_i  (sel),
      .lo_i   (lo_in[i]),
      .hi_i   (hi_in[i]),
      .ld_i   (D[i]),
      .q_o    (q_q[i])
    );
  end

  // Counter saturates at WIDTH; Done fires only on the WIDTH-1 -> WIDTH step.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (shift_op && (cnt_q < CNT_MAX)) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_MAX - CNT_W'(1));
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q        = q_q;
  assign SoutL    = q_q[WIDTH-1];
  assign SoutR    = q_q[0];
  assign ShiftCnt = cnt_q;
  assign Full     = (cnt_q == CNT_MAX);
  assign Done     = done_q;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Randomised bench for usr_shift_reg with a word-level reference model and a
// set of directed literal checks; honours USR_ROTATE_EN like the design.
module tb_usr_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic          En;
  logic [2:0]    Mode;
  logic [W-1:0]  D;
  logic          SinL;
  logic          SinR;
  logic [W-1:0]  Q;
  logic          SoutL;
  logic          SoutR;
  logic [CW-1:0] ShiftCnt;
  logic          Full;
  logic          Done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [W-1:0] m_q;
  int           m_cnt;
  bit           m_done;

  always #5 Clk = ~Clk;

  usr_shift_reg #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Mode     (Mode),
    .D        (D),
    .SinL     (SinL),
    .SinR     (SinR),
    .Q        (Q),
    .SoutL    (SoutL),
    .SoutR    (SoutR),
    .ShiftCnt (ShiftCnt),
    .Full     (Full),
    .Done     (Done)
  );

  // Word-level reference: plain arithmetic on the whole register value.
  always @(posedge Clk) begin
    bit sh;
    sh     = 1'b0;
    m_done = 1'b0;
    if (!Reset) begin
      m_q   = '0;
      m_cnt = 0;
    end else if (En) begin
      case (Mode)
        3'd1: begin m_q = W'((m_q * 2) + SinL); sh = 1'b1; end
        3'd2: begin m_q = W'((m_q / 2) + (SinR ? (1 << (W - 1)) : 0)); sh = 1'b1; end
        3'd3: begin m_q = D; m_cnt = 0; end
        3'd4: begin m_q = W'($signed(m_q) >>> 1); sh = 1'b1; end
`ifdef USR_ROTATE_EN
        3'd5: begin m_q = W'((m_q * 2) + m_q[W-1]); sh = 1'b1; end
        3'd6: begin m_q = W'((m_q / 2) + (m_q[0] ? (1 << (W - 1)) : 0)); sh = 1'b1; end
`endif
        3'd7: begin m_q = '0; m_cnt = 0; end
        default: ;
      endcase
      if (sh && m_cnt < W) begin
        m_cnt  = m_cnt + 1;
        m_done = (m_cnt == W);
      end
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("model_Q", int'(Q), int'(m_q));
      cmp("model_SoutL", int'(SoutL), int'(m_q[W-1]));
      cmp("model_SoutR", int'(SoutR), int'(m_q[0]));
      cmp("model_ShiftCnt", int'(ShiftCnt), m_cnt);
      cmp("model_Full", int'(Full), int'(m_cnt == W));
      cmp("model_Done", int'(Done), int'(m_done));
    end
  end

  task automatic tick(input bit rst_n, input bit en, input int mode,
                      input int d, input bit sl, input bit sr);
    @(negedge Clk);
    Reset = rst_n;
    En    = en;
    Mode  = 3'(mode);
    D     = W'(d);
    SinL  = sl;
    SinR  = sr;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bit [7:0] pat;
    int rot_l;
    int rot_r;
    int rot_c;
    pat   = 8'b1011_0010;
`ifdef USR_ROTATE_EN
    rot_l = 8'h03; rot_r = 8'hC0; rot_c = 1;
`else
    rot_l = 8'h81; rot_r = 8'h81; rot_c = 0;
`endif
    Reset = 1'b0; En = 1'b0; Mode = '0; D = '0; SinL = 1'b0; SinR = 1'b0;
    tick(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset behaviour
    tick(1, 1, 3, 'hA5, 0, 0);
    cmp("load_A5", int'(Q), 'hA5);
    tick(0, 1, 1, 0, 1, 0);
    cmp("rst_Q", int'(Q), 0);
    cmp("rst_cnt", int'(ShiftCnt), 0);
    cmp("rst_full", int'(Full), 0);
    cmp("rst_done", int'(Done), 0);
    tick(1, 1, 3, 'hA5, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    cmp("rst_en0_Q", int'(Q), 0);

    // Load, shifts
    tick(1, 1, 3, 'h81, 0, 0);
    tick(1, 1, 1, 0, 1, 0);
    cmp("shl_Q", int'(Q), 'h03);
    cmp("shl_cnt", int'(ShiftCnt), 1);
    cmp("shl_soutl", int'(SoutL), 0);
    tick(1, 1, 3, 'h81, 0, 0);
    tick(1, 1, 2, 0, 0, 0);
    cmp("shr_Q", int'(Q), 'h40);
    tick(1, 1, 3, 'h90, 0, 0);
    tick(1, 1, 4, 0, 0, 1);
    cmp("asr1_Q", int'(Q), 'hC8);
    tick(1, 1, 4, 0, 0, 0);
    cmp("asr2_Q", int'(Q), 'hE4);

    // Serial fill to saturation
    tick(1, 1, 7, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 1, 0, pat[7-i], 0);
      if (i == 6) cmp("fill7_done", int'(Done), 0);
    end
    cmp("fill_Q", int'(Q), 'hB2);
    cmp("fill_cnt", int'(ShiftCnt), 8);
    cmp("fill_full", int'(Full), 1);
    cmp("fill_done", int'(Done), 1);
    tick(1, 1, 1, 0, 0, 0);
    cmp("sat_cnt", int'(ShiftCnt), 8);
    cmp("sat_done", int'(Done), 0);
    cmp("sat_Q", int'(Q), 'h64);

    // Enable and LOAD while full
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 1, 1);
    cmp("en0_Q", int'(Q), 'h64);
    cmp("en0_cnt", int'(ShiftCnt), 8);
    tick(1, 1, 3, 'h55, 0, 0);
    cmp("loadfull_cnt", int'(ShiftCnt), 0);
    cmp("loadfull_full", int'(Full), 0);
    cmp("loadfull_done", int'(Done), 0);

    // Rotates
    tick(1, 1, 3, 'h81, 0, 0);
    tick(1, 1, 5, 0, 0, 0);
    cmp("rol_Q", int'(Q), rot_l);
    cmp("rol_cnt", int'(ShiftCnt), rot_c);
    tick(1, 1, 3, 'h81, 0, 0);
    tick(1, 1, 6, 0, 1, 1);
    cmp("ror_Q", int'(Q), rot_r);
    cmp("ror_cnt", int'(ShiftCnt), rot_c);

    // Random traffic, biased toward shifts so the counter saturates often
    for (int i = 0; i < 3000; i++) begin
      int m;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55)      m = (r % 2 == 0) ? 1 : ((r % 3 == 0) ? 4 : 2);
      else if (r < 65) m = int'($urandom_range(5, 6));
      else if (r < 75) m = 0;
      else if (r < 88) m = 3;
      else             m = 7;
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), m,
           int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    end

    @(negedge Clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
